// File: rtl/radar_arp_acp_conditioner.sv
// Radar ARP/ACP front end: synchronise, deglitch and edge-detect both
// antenna lines, then measure ACPs per revolution and revolution period.

module radar_arp_acp_chan #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic raw_i,
    output logic rise_o,
    output logic pe_o
);

    localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

    logic       s1_q, s2_q, filt_q, pe_q;
    logic [7:0] fcnt_q;
    logic       s1_d, s2_d, filt_d, pe_d;
    logic [7:0] fcnt_d;
    logic       differ, done;

    assign differ = s2_q ^ filt_q;
    assign done   = differ && (fcnt_q == LAST);
    assign rise_o = done & s2_q;
    assign pe_o   = pe_q;

    always_comb begin
        s1_d   = raw_i;
        s2_d   = s1_q;
        filt_d = filt_q;
        fcnt_d = 8'd0;
        pe_d   = en_i & rise_o;
        if (done) begin
            filt_d = s2_q;
        end else if (differ) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            fcnt_q <= 8'd0;
            pe_q   <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            pe_q   <= pe_d;
        end
    end

endmodule

module radar_arp_acp_conditioner #(
    parameter int FILTER_LEN = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 EN,
    input  logic                 RADAR_ARP,
    input  logic                 RADAR_ACP,
    output logic                 RADAR_ARP_PE,
    output logic                 RADAR_ACP_PE,
    output logic [CNT_WIDTH-1:0] ACP_CNT,
    output logic [CNT_WIDTH-1:0] ACP_PER_ARP,
    output logic [CNT_WIDTH-1:0] ARP_PERIOD,
    output logic                 ARP_VALID
);

    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic arp_rise, acp_rise, arp_go, acp_go;

    radar_arp_acp_chan #(.FILTER_LEN(FILTER_LEN)) u_arp (
        .clk_i  (ACLK),
        .rst_ni (ARESETN),
        .en_i   (EN),
        .raw_i  (RADAR_ARP),
        .rise_o (arp_rise),
        .pe_o   (RADAR_ARP_PE)
    );

    radar_arp_acp_chan #(.FILTER_LEN(FILTER_LEN)) u_acp (
        .clk_i  (ACLK),
        .rst_ni (ARESETN),
        .en_i   (EN),
        .raw_i  (RADAR_ACP),
        .rise_o (acp_rise),
        .pe_o   (RADAR_ACP_PE)
    );

    logic [CNT_WIDTH-1:0] acp_cnt_q, pcnt_q, per_q, period_q;
    logic [CNT_WIDTH-1:0] acp_cnt_d, pcnt_d, per_d, period_d;
    logic                 valid_q, seen_q, valid_d, seen_d;
    logic [CNT_WIDTH-1:0] acp_inc, acp_end, pcnt_inc;

    assign arp_go   = EN & arp_rise;
    assign acp_go   = EN & acp_rise;
    assign acp_inc  = (acp_cnt_q == MAX) ? MAX : acp_cnt_q + ONE;
    assign pcnt_inc = (pcnt_q == MAX) ? MAX : pcnt_q + ONE;
    // a coincident ACP is credited to the revolution that is ending
    assign acp_end  = acp_go ? acp_inc : acp_cnt_q;

    always_comb begin
        acp_cnt_d = acp_cnt_q;
        pcnt_d    = pcnt_q;
        per_d     = per_q;
        period_d  = period_q;
        valid_d   = valid_q;
        seen_d    = seen_q;
        if (!EN) begin
            acp_cnt_d = '0;
            pcnt_d    = '0;
            per_d     = '0;
            period_d  = '0;
            valid_d   = 1'b0;
            seen_d    = 1'b0;
        end else if (arp_go) begin
            acp_cnt_d = '0;
            pcnt_d    = '0;
            seen_d    = 1'b1;
            if (seen_q) begin
                per_d    = acp_end;
                period_d = pcnt_inc;
                valid_d  = 1'b1;
            end
        end else begin
            acp_cnt_d = acp_end;
            pcnt_d    = pcnt_inc;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acp_cnt_q <= '0;
            pcnt_q    <= '0;
            per_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            acp_cnt_q <= acp_cnt_d;
            pcnt_q    <= pcnt_d;
            per_q     <= per_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            seen_q    <= seen_d;
        end
    end

    assign ACP_CNT     = acp_cnt_q;
    assign ACP_PER_ARP = per_q;
    assign ARP_PERIOD  = period_q;
    assign ARP_VALID   = valid_q;

endmodule

// File: tb/tb_radar_arp_acp_conditioner.sv
// Bench for radar_arp_acp_conditioner: directed scenarios plus random
// line activity, checked each cycle against a window-based reference.

module tb_radar_arp_acp_conditioner;

    localparam int FL   = 8;
    localparam int CW   = 12;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          arp_raw = 1'b0;
    logic          acp_raw = 1'b0;
    logic          arp_pe, acp_pe, valid;
    logic [CW-1:0] acp_cnt, acp_per, arp_period;

    radar_arp_acp_conditioner #(.FILTER_LEN(FL), .CNT_WIDTH(CW)) dut (
        .ACLK         (clk),
        .ARESETN      (rst_n),
        .EN           (en),
        .RADAR_ARP    (arp_raw),
        .RADAR_ACP    (acp_raw),
        .RADAR_ARP_PE (arp_pe),
        .RADAR_ACP_PE (acp_pe),
        .ACP_CNT      (acp_cnt),
        .ACP_PER_ARP  (acp_per),
        .ARP_PERIOD   (arp_period),
        .ARP_VALID    (valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: a level flips once the last FL synchronised samples all disagree
    bit d1[2], d2[2], filt[2], m_rise[2];
    bit win[2][FL];
    int m_cnt, m_pcnt, m_per, m_period;
    bit m_valid, m_seen, m_arp_pe, m_acp_pe;
    bit chk_on = 1'b0;

    function automatic int sat(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            d1[c] = 0; d2[c] = 0; filt[c] = 0; m_rise[c] = 0;
            for (int i = 0; i < FL; i++) win[c][i] = 0;
        end
        m_cnt = 0; m_pcnt = 0; m_per = 0; m_period = 0;
        m_valid = 0; m_seen = 0; m_arp_pe = 0; m_acp_pe = 0;
    endfunction

    function automatic void model_step();
        bit raw[2];
        int nxt_p, end_c;
        raw[0] = arp_raw;
        raw[1] = acp_raw;
        for (int c = 0; c < 2; c++) begin
            bit s2;
            bit flip;
            s2 = d2[c];
            flip = 1;
            for (int i = FL - 1; i > 0; i--) win[c][i] = win[c][i-1];
            win[c][0] = s2;
            for (int i = 0; i < FL; i++)
                if (win[c][i] == filt[c]) flip = 0;
            m_rise[c] = 0;
            if (flip) begin
                filt[c] = s2;
                m_rise[c] = s2;
            end
            d2[c] = d1[c];
            d1[c] = raw[c];
        end
        if (!en) begin
            m_arp_pe = 0; m_acp_pe = 0; m_cnt = 0; m_pcnt = 0;
            m_per = 0; m_period = 0; m_valid = 0; m_seen = 0;
        end else begin
            nxt_p = sat(m_pcnt + 1);
            end_c = m_rise[1] ? sat(m_cnt + 1) : m_cnt;
            m_arp_pe = m_rise[0];
            m_acp_pe = m_rise[1];
            if (m_rise[0]) begin
                if (m_seen) begin
                    m_per = end_c;
                    m_period = nxt_p;
                    m_valid = 1;
                end
                m_seen = 1;
                m_cnt = 0;
                m_pcnt = 0;
            end else begin
                m_cnt = end_c;
                m_pcnt = nxt_p;
            end
        end
    endfunction

    initial model_reset();

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("arp_pe", 64'(arp_pe), 64'(m_arp_pe));
            check("acp_pe", 64'(acp_pe), 64'(m_acp_pe));
            check("acp_cnt", 64'(acp_cnt), 64'(m_cnt));
            check("acp_per_arp", 64'(acp_per), 64'(m_per));
            check("arp_period", 64'(arp_period), 64'(m_period));
            check("arp_valid", 64'(valid), 64'(m_valid));
        end
    end

    task automatic run(input int n, input bit a, input bit c,
                       inout int na, inout int nc);
        arp_raw = a;
        acp_raw = c;
        repeat (n) begin
            @(negedge clk);
            na += int'(arp_pe);
            nc += int'(acp_pe);
        end
    endtask

    task automatic wait_pe(input bit which, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (which ? acp_pe : arp_pe) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arp_pe"}, 64'(arp_pe), 64'd0);
        check({tag, "_acp_pe"}, 64'(acp_pe), 64'd0);
        check({tag, "_cnt"}, 64'(acp_cnt), 64'd0);
        check({tag, "_per"}, 64'(acp_per), 64'd0);
        check({tag, "_period"}, 64'(arp_period), 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nc, lat, arem, crem;
        na = 0;
        nc = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        chk_on = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            acp_raw = 1'b1;
            wait_pe(1, 40, lat);
            check("acp_lat", 64'(lat), 64'd10);
            check("acp_cnt_k", 64'(acp_cnt), 64'(k));
            run(20 - lat, 0, 1, na, nc);
            run(20, 0, 0, na, nc);
        end

        nc = 0;
        run(7, 0, 1, na, nc);
        run(20, 0, 0, na, nc);
        check("glitch_pe", 64'(nc), 64'd0);
        check("glitch_cnt", 64'(acp_cnt), 64'd5);
        nc = 0;
        run(10, 0, 1, na, nc);
        run(1, 0, 0, na, nc);
        run(19, 0, 1, na, nc);
        run(20, 0, 0, na, nc);
        check("lowglitch_pe", 64'(nc), 64'd1);
        check("lowglitch_cnt", 64'(acp_cnt), 64'd6);

        arp_raw = 1'b1;
        wait_pe(0, 40, lat);
        check("arp1_lat", 64'(lat), 64'd10);
        check("arp1_valid", 64'(valid), 64'd0);
        check("arp1_cnt", 64'(acp_cnt), 64'd0);
        run(20 - lat, 1, 0, na, nc);
        for (int k = 0; k < 16; k++) begin
            run(10, 0, 1, na, nc);
            run(10, 0, 0, na, nc);
        end
        run(60, 0, 0, na, nc);
        arp_raw = 1'b1;
        wait_pe(0, 40, lat);
        check("rev_per", 64'(acp_per), 64'd16);
        check("rev_period", 64'(arp_period), 64'd400);
        check("rev_valid", 64'(valid), 64'd1);
        check("rev_cnt", 64'(acp_cnt), 64'd0);

        run(20 - lat, 1, 0, na, nc);
        run(20, 0, 0, na, nc);
        for (int k = 0; k < 3; k++) begin
            run(10, 0, 1, na, nc);
            run(10, 0, 0, na, nc);
        end
        arp_raw = 1'b1;
        acp_raw = 1'b1;
        wait_pe(0, 40, lat);
        check("sim_acp_pe", 64'(acp_pe), 64'd1);
        check("sim_per", 64'(acp_per), 64'd4);
        check("sim_cnt", 64'(acp_cnt), 64'd0);
        check("sim_period", 64'(arp_period), 64'd100);
        run(20 - lat, 1, 1, na, nc);
        run(20, 0, 0, na, nc);

        en = 1'b0;
        na = 0;
        nc = 0;
        for (int k = 0; k < 10; k++) begin
            run(10, 0, 1, na, nc);
            run(10, 0, 0, na, nc);
        end
        check("en_off_pe", 64'(nc), 64'd0);
        check_all_zero("en_off");
        run(20, 0, 1, na, nc);
        en = 1'b1;
        nc = 0;
        run(30, 0, 1, na, nc);
        check("en_rise_nope", 64'(nc), 64'd0);
        run(20, 0, 0, na, nc);
        acp_raw = 1'b1;
        wait_pe(1, 40, lat);
        check("en_refire", 64'(lat), 64'd10);
        check("en_refire_cnt", 64'(acp_cnt), 64'd1);
        run(20 - lat, 0, 1, na, nc);
        run(20, 0, 0, na, nc);
        run(20, 1, 0, na, nc);
        run(30, 0, 0, na, nc);
        check("en_valid0", 64'(valid), 64'd0);
        arp_raw = 1'b1;
        wait_pe(0, 40, lat);
        check("en_valid1", 64'(valid), 64'd1);
        check("en_period", 64'(arp_period), 64'd50);
        run(20 - lat, 1, 0, na, nc);
        run(20, 0, 0, na, nc);

        run(4200, 0, 0, na, nc);
        arp_raw = 1'b1;
        wait_pe(0, 40, lat);
        check("sat_period", 64'(arp_period), 64'(MAXV));
        run(20 - lat, 1, 0, na, nc);
        run(20, 0, 0, na, nc);

        for (int k = 0; k < 9; k++) begin
            run(10, 0, 1, na, nc);
            run(10, 0, 0, na, nc);
        end
        check("pre_rst_cnt", 64'(acp_cnt), 64'd9);
        acp_raw = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_pe(1, 40, lat);
        check("rst_rel_lat", 64'(lat), 64'd10);
        run(20 - lat, 0, 1, na, nc);
        run(20, 0, 0, na, nc);

        arem = 1;
        crem = 1;
        for (int cyc = 0; cyc < 15000; cyc++) begin
            arem--;
            if (arem == 0) begin
                arp_raw = ~arp_raw;
                arem = arp_raw ? int'($urandom_range(1, 30))
                               : int'($urandom_range(1, 700));
            end
            crem--;
            if (crem == 0) begin
                acp_raw = ~acp_raw;
                crem = int'($urandom_range(1, 20));
            end
            if ($urandom_range(0, 799) == 0) en = ~en;
            @(negedge clk);
        end
        en = 1'b1;
        run(40, 0, 0, na, nc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
